// File: rtl/ex_stage.sv
// Execute stage with operand forwarding and the EX/MEM pipeline register.
// Optional iterative divider is built only when EX_DIV_EN is defined.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] imme,
  input  logic [XLEN-1:0] instr,
  input  logic [13:0]     addr,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            RegWrite,
  input  logic            ALUSrc,
  input  logic [3:0]      ALUControl,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall,
  output logic            valid_o,
  output logic            RegWrite_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] instr_o,
  output logic [13:0]     addr_o
);

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res;
  logic            exm_fwd_ok;

  assign exm_fwd_ok = valid_o & RegWrite_o & (rd_o != 5'd0);

  // EX/MEM beats WB; x0 never forwards from either source
  always_comb begin
    op_a = rdata1;
    if (exm_fwd_ok && rd_o == rs1)
      op_a = alu_result_o;
    else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs1)
      op_a = wb_data;
    fwd_b = rdata2;
    if (exm_fwd_ok && rd_o == rs2)
      fwd_b = alu_result_o;
    else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs2)
      fwd_b = wb_data;
  end

  assign op_b = ALUSrc ? imme : fwd_b;

  always_comb begin
    alu_res = '0;
    case (ALUControl)
      4'h0: alu_res = op_a + op_b;
      4'h1: alu_res = op_a - op_b;
      4'h2: alu_res = op_a & op_b;
      4'h3: alu_res = op_a | op_b;
      4'h4: alu_res = op_a ^ op_b;
      4'h5: alu_res = op_a << op_b[4:0];
      4'h6: alu_res = op_a >> op_b[4:0];
      4'h7: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'h8: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'h9: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'hA: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  logic            launch, busy, done;
  logic [XLEN-1:0] div_res, lat_store, lat_instr;
  logic [4:0]      lat_rd;
  logic            lat_rw;
  logic [13:0]     lat_addr;

`ifdef EX_DIV_EN
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo_q, rem_q, divisor_q, dividend_q;
  logic            neg_q, neg_r, div_zero, want_rem;
  logic            is_div, is_signed, a_neg, b_neg;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] q_fix, r_fix;

  assign is_div    = (ALUControl >= 4'hB) && (ALUControl <= 4'hE);
  assign is_signed = (ALUControl == 4'hB) || (ALUControl == 4'hD);
  assign a_neg     = is_signed & op_a[XLEN-1];
  assign b_neg     = is_signed & op_b[XLEN-1];
  assign launch    = (state == S_IDLE) & in_valid & is_div & ~flush;
  assign busy      = (state == S_BUSY);
  assign done      = (state == S_DONE);
  assign stall     = rst_n & (launch | busy);

  // Restoring step: shift next dividend bit into the partial remainder
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, divisor_q};

  assign q_fix   = neg_q ? -quo_q : quo_q;
  assign r_fix   = neg_r ? -rem_q : rem_q;
  assign div_res = div_zero ? (want_rem ? dividend_q : '1)
                            : (want_rem ? r_fix : q_fix);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
      want_rem   <= 1'b0;
      lat_rd     <= '0;
      lat_rw     <= 1'b0;
      lat_store  <= '0;
      lat_instr  <= '0;
      lat_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: if (launch) begin
          state      <= S_BUSY;
          cnt        <= CW'(DIV_CYCLES - 1);
          quo_q      <= a_neg ? -op_a : op_a;
          rem_q      <= '0;
          divisor_q  <= b_neg ? -op_b : op_b;
          dividend_q <= op_a;
          neg_q      <= a_neg ^ b_neg;
          neg_r      <= a_neg;
          div_zero   <= (op_b == '0);
          want_rem   <= (ALUControl == 4'hD) || (ALUControl == 4'hE);
          lat_rd     <= rd;
          lat_rw     <= RegWrite;
          lat_store  <= fwd_b;
          lat_instr  <= instr;
          lat_addr   <= addr;
        end
        S_BUSY: if (flush) begin
          state <= S_IDLE;
        end else begin
          rem_q <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_div_cfg;
  assign unused_div_cfg = (DIV_CYCLES != XLEN);
  assign launch    = 1'b0;
  assign busy      = 1'b0;
  assign done      = 1'b0;
  assign stall     = 1'b0;
  assign div_res   = '0;
  assign lat_rd    = '0;
  assign lat_rw    = 1'b0;
  assign lat_store = '0;
  assign lat_instr = '0;
  assign lat_addr  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o      <= 1'b0;
      RegWrite_o   <= 1'b0;
      rd_o         <= '0;
      alu_result_o <= '0;
      store_data_o <= '0;
      instr_o      <= '0;
      addr_o       <= '0;
    end else if (flush || busy || launch) begin
      valid_o    <= 1'b0;
      RegWrite_o <= 1'b0;
    end else if (done) begin
      valid_o      <= 1'b1;
      RegWrite_o   <= lat_rw;
      rd_o         <= lat_rd;
      alu_result_o <= div_res;
      store_data_o <= lat_store;
      instr_o      <= lat_instr;
      addr_o       <= lat_addr;
    end else begin
      valid_o      <= in_valid;
      RegWrite_o   <= RegWrite & in_valid;
      rd_o         <= rd;
      alu_result_o <= alu_res;
      store_data_o <= fwd_b;
      instr_o      <= instr;
      addr_o       <= addr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table through a scoreboard, plus divider,
// flush and reset sequences (divider sequences only when EX_DIV_EN is defined).
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, RegWrite, ALUSrc, wb_RegWrite, flush;
  logic [31:0] rdata1, rdata2, imme, instr, wb_data;
  logic [13:0] addr;
  logic [4:0]  rd, rs1, rs2, wb_rd;
  logic [3:0]  ALUControl;
  logic        stall, valid_o, RegWrite_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_result_o, store_data_o, instr_o;
  logic [13:0] addr_o;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rdata1(rdata1), .rdata2(rdata2),
    .imme(imme), .instr(instr), .addr(addr), .rd(rd), .rs1(rs1), .rs2(rs2),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .stall(stall), .valid_o(valid_o), .RegWrite_o(RegWrite_o), .rd_o(rd_o),
    .alu_result_o(alu_result_o), .store_data_o(store_data_o), .instr_o(instr_o),
    .addr_o(addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] r1, r2, imm;
    logic        src;
    logic [3:0]  ctl;
    logic        vld, rw, wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd, res, st;
  } vec_t;

  typedef struct {
    logic        vld, rw;
    logic [4:0]  rd;
    logic [31:0] res, st, ins;
    logic [13:0] ad;
  } out_t;

  vec_t vecs[$];
  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                     input logic src, input logic [3:0] ctl, input logic vld, input logic rw,
                     input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                     input logic [31:0] res, input logic [31:0] st);
    vec_t v;
    v.rs1 = a; v.rs2 = b; v.rd = d; v.r1 = r1; v.r2 = r2; v.imm = im; v.src = src;
    v.ctl = ctl; v.vld = vld; v.rw = rw; v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd;
    v.res = res; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v, input logic [31:0] ins, input logic [13:0] ad);
    out_t e;
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; rdata1 = v.r1; rdata2 = v.r2; imme = v.imm;
    ALUSrc = v.src; ALUControl = v.ctl; in_valid = v.vld; RegWrite = v.rw;
    wb_RegWrite = v.wbw; wb_rd = v.wbrd; wb_data = v.wbd; instr = ins; addr = ad;
    e.vld = v.vld; e.rw = v.rw & v.vld; e.rd = v.rd; e.res = v.res; e.st = v.st;
    e.ins = ins; e.ad = ad;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    out_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty, got result %h, expected an entry", tag, alu_result_o);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".valid"},  32'(valid_o),    32'(e.vld));
      cmp({tag, ".regw"},   32'(RegWrite_o), 32'(e.rw));
      cmp({tag, ".rd"},     32'(rd_o),       32'(e.rd));
      cmp({tag, ".result"}, alu_result_o,    e.res);
      cmp({tag, ".store"},  store_data_o,    e.st);
      cmp({tag, ".instr"},  instr_o,         e.ins);
      cmp({tag, ".addr"},   32'(addr_o),     32'(e.ad));
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".stall"}, 32'(stall),      32'd0);
    cmp({tag, ".valid"}, 32'(valid_o),    32'd0);
    cmp({tag, ".regw"},  32'(RegWrite_o), 32'd0);
    cmp({tag, ".rd"},    32'(rd_o),       32'd0);
    cmp({tag, ".res"},   alu_result_o,    32'd0);
    cmp({tag, ".store"}, store_data_o,    32'd0);
    cmp({tag, ".instr"}, instr_o,         32'd0);
    cmp({tag, ".addr"},  32'(addr_o),     32'd0);
  endtask

  task automatic div_vec(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res);
    vec_t v;
    v.rs1 = 5'd20; v.rs2 = 5'd21; v.rd = 5'd5; v.r1 = a; v.r2 = b; v.imm = 32'h0;
    v.src = 1'b0; v.ctl = ctl; v.vld = 1'b1; v.rw = 1'b1; v.wbw = 1'b0; v.wbrd = 5'd0;
    v.wbd = 32'h0; v.res = res; v.st = b;
    drive(v, 32'hD1D0_0000 | 32'(ctl), 14'h3FF);
  endtask

`ifdef EX_DIV_EN
  task automatic run_div(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res);
    int cnt = 0;
    div_vec(ctl, a, b, res);
    while (stall === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
      if (cnt == 1) begin
        rdata1 = 32'h1234_5678;
        rdata2 = 32'h0000_0003;
      end
    end
    cmp({tag, ".stall_cycles"}, 32'(cnt), 32'd33);
    cmp({tag, ".done_bubble"}, 32'(valid_o), 32'd0);
    tick();
    in_valid = 1'b0;
    check_out(tag);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; RegWrite = 1'b0; ALUSrc = 1'b0; wb_RegWrite = 1'b0;
    flush = 1'b0; rdata1 = '0; rdata2 = '0; imme = '0; instr = '0; wb_data = '0;
    addr = '0; rd = '0; rs1 = '0; rs2 = '0; wb_rd = '0; ALUControl = '0;
    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;

    //   rs1 rs2 rd  rdata1         rdata2         imme           src ctl  v  rw wbw wbrd wbdata  result         store
    add(10, 11,  1, 32'd5,         32'd7,         32'd0,         0, 4'h0, 1, 1, 0, 0,  32'd0,  32'd12,        32'd7);
    add( 1,  1,  2, 32'd0,         32'd0,         32'd0,         0, 4'h0, 1, 1, 0, 0,  32'd0,  32'd24,        32'd12);
    add( 0,  0,  3, 32'd4,         32'd6,         32'd0,         1, 4'h0, 1, 1, 1, 0,  32'd99, 32'd4,         32'd6);
    add( 3,  3,  5, 32'd100,       32'd100,       32'd1,         1, 4'h1, 1, 1, 1, 3,  32'd9,  32'd3,         32'd4);
    add( 3,  7,  6, 32'd0,         32'd2,         32'd0,         0, 4'h3, 1, 1, 1, 3,  32'd9,  32'd11,        32'd2);
    add( 6,  0,  0, 32'd0,         32'hFF,        32'd0,         0, 4'h4, 1, 1, 0, 0,  32'd0,  32'hF4,        32'hFF);
    add( 0,  0,  7, 32'h10,        32'd0,         32'd4,         1, 4'h5, 1, 1, 1, 0,  32'd5,  32'h100,       32'd0);
    add( 8,  9,  8, 32'h8000_0000, 32'h33,        32'd31,        1, 4'h6, 1, 1, 0, 0,  32'd0,  32'd1,         32'h33);
    add(10, 10,  9, 32'h8000_0000, 32'd0,         32'h24,        1, 4'h7, 1, 1, 0, 0,  32'd0,  32'hF800_0000, 32'd0);
    add(11, 12, 10, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 4'h8, 1, 1, 0, 0,  32'd0,  32'd1,         32'd1);
    add(11, 12, 11, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 4'h9, 1, 1, 0, 0,  32'd0,  32'd0,         32'd1);
    add( 0,  0, 12, 32'd0,         32'd0,         32'hABCD_E000, 1, 4'hA, 1, 1, 0, 0,  32'd0,  32'hABCD_E000, 32'd0);
    add(13, 14, 13, 32'hFFFF_FFFF, 32'd2,         32'd0,         0, 4'h0, 1, 1, 0, 0,  32'd0,  32'd1,         32'd2);
    add(15, 16, 14, 32'd0,         32'd1,         32'd0,         0, 4'h1, 1, 1, 0, 0,  32'd0,  32'hFFFF_FFFF, 32'd1);
    add(17, 18, 15, 32'd5,         32'd6,         32'd0,         0, 4'hF, 1, 1, 0, 0,  32'd0,  32'd0,         32'd6);
    add(19, 20, 16, 32'd1,         32'd1,         32'd0,         0, 4'h0, 0, 1, 0, 0,  32'd0,  32'd2,         32'd1);
    add(16, 22, 17, 32'hF0F0,      32'hFF00,      32'd0,         0, 4'h2, 1, 0, 0, 0,  32'd0,  32'hF000,      32'hFF00);
    add(17,  0, 18, 32'd3,         32'd0,         32'd4,         1, 4'h0, 1, 1, 0, 0,  32'd0,  32'd7,         32'd0);
    add(23, 24, 19, 32'd5,         32'hFFFF_FFFF, 32'd0,         0, 4'h8, 1, 1, 0, 0,  32'd0,  32'd0,         32'hFFFF_FFFF);
    add(23, 24, 20, 32'd5,         32'hFFFF_FFFF, 32'd0,         0, 4'h9, 1, 1, 0, 0,  32'd0,  32'd1,         32'hFFFF_FFFF);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], 32'h00A0_0000 + 32'(i), 14'(100 + i));
      cmp($sformatf("vec%0d.stall", i), 32'(stall), 32'd0);
      tick();
      check_out($sformatf("vec%0d", i));
    end
    wb_RegWrite = 1'b0;

    // Flush kills an ordinary instruction
    flush = 1'b1;
    drive(vecs[0], 32'h0000_0F00, 14'd7);
    void'(sb.pop_back());
    tick();
    cmp("flush_alu.valid", 32'(valid_o), 32'd0);
    cmp("flush_alu.regw", 32'(RegWrite_o), 32'd0);
    flush = 1'b0;

`ifdef EX_DIV_EN
    run_div("div_m7_2",   4'hB, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_div("rem_m7_2",   4'hD, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_div("div_7_m2",   4'hB, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_div("rem_7_m2",   4'hD, 32'd7,         32'hFFFF_FFFE, 32'd1);
    run_div("divu_5_0",   4'hC, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_div("rem_5_0",    4'hD, 32'd5,         32'd0,         32'd5);
    run_div("div_ovf",    4'hB, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("rem_ovf",    4'hD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("divu_big",   4'hC, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF);
    run_div("remu_100_7", 4'hE, 32'd100,       32'd7,         32'd2);

    // Flush at BUSY cycle 10 aborts the divide
    div_vec(4'hB, 32'd100, 32'd3, 32'd33);
    void'(sb.pop_back());
    cmp("flushdiv.stall0", 32'(stall), 32'd1);
    for (int i = 0; i < 11; i++) tick();
    cmp("flushdiv.busy_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp("flushdiv.valid", 32'(valid_o), 32'd0);
    cmp("flushdiv.stall", 32'(stall), 32'd0);
    drive(vecs[0], 32'h0000_0ADD, 14'd9);
    tick();
    check_out("after_flush_add");

    // Reset at BUSY cycle 5
    div_vec(4'hC, 32'd1000, 32'd10, 32'd100);
    void'(sb.pop_back());
    for (int i = 0; i < 6; i++) tick();
    cmp("rstdiv.busy_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    tick();
    check_zero("rstdiv");
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
`else
    // Divide codes behave as reserved: result 0, single cycle, no stall
    div_vec(4'hB, 32'hFFFF_FFF9, 32'd2, 32'd0);
    cmp("nodiv.stall", 32'(stall), 32'd0);
    tick();
    check_out("nodiv_div");
    div_vec(4'hE, 32'd100, 32'd7, 32'd0);
    cmp("nodiv_remu.stall", 32'(stall), 32'd0);
    tick();
    check_out("nodiv_remu");
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check_zero("reset2");
    rst_n = 1'b1;
`endif

    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
